// File: rtl/snn_spike_decoder.sv
// Spike-train output decoder: counts signed spikes on two channels over a window and reports the winner.
// Optional early exit on a large count difference is enabled by defining SNN_DECODE_EARLY_EXIT_EN.
module snn_spike_decoder #(
    parameter int CNT_W  = 8,
    parameter int WINDOW = 64,
    parameter int WIN_W  = 7,
    parameter int MARGIN = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             data_in_a,
    input  logic             sign_in_a,
    input  logic             data_in_b,
    input  logic             sign_in_b,
    input  logic             result_ready,
    output logic             busy,
    output logic             result_valid,
    output logic             winner,
    output logic             tie,
    output logic [CNT_W-1:0] count_a,
    output logic [CNT_W-1:0] count_b
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic signed [CNT_W-1:0] MAX_V    = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] MIN_V    = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic signed [CNT_W-1:0] ONE_V    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIN_W-1:0]        WIN_LOAD = WIN_W'(WINDOW - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [WIN_W-1:0]        win_cnt;
    logic signed [CNT_W-1:0] cnt_a_q;
    logic signed [CNT_W-1:0] cnt_b_q;
    logic signed [CNT_W-1:0] cnt_a_nxt;
    logic signed [CNT_W-1:0] cnt_b_nxt;
    logic                    winner_q;
    logic                    tie_q;
    logic                    last_sample;
    logic                    exit_early;

    // Saturating +/-1 step; an absent spike leaves the count alone whatever the sign line says.
    function automatic logic signed [CNT_W-1:0] sat_step(
        input logic signed [CNT_W-1:0] cur,
        input logic                    spike,
        input logic                    neg
    );
        logic signed [CNT_W-1:0] res;
        res = cur;
        if (spike) begin
            if (!neg && (cur != MAX_V)) begin
                res = cur + ONE_V;
            end else if (neg && (cur != MIN_V)) begin
                res = cur - ONE_V;
            end
        end
        return res;
    endfunction

    always_comb begin
        cnt_a_nxt = cnt_a_q;
        cnt_b_nxt = cnt_b_q;
        if (state == ACCUM) begin
            cnt_a_nxt = sat_step(cnt_a_q, data_in_a, sign_in_a);
            cnt_b_nxt = sat_step(cnt_b_q, data_in_b, sign_in_b);
        end
    end

    assign last_sample = (win_cnt == '0);

`ifdef SNN_DECODE_EARLY_EXIT_EN
    logic signed [CNT_W:0] diff;
    logic [CNT_W:0]        diff_abs;

    // Difference is taken one bit wider so that MAX_V - MIN_V cannot overflow.
    always_comb begin
        diff     = {cnt_a_nxt[CNT_W-1], cnt_a_nxt} - {cnt_b_nxt[CNT_W-1], cnt_b_nxt};
        diff_abs = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
        exit_early = (state == ACCUM) && (int'(diff_abs) >= MARGIN);
    end
`else
    logic margin_unused;

    assign margin_unused = (MARGIN != 0);
    assign exit_early    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (last_sample || exit_early) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (result_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt  <= '0;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            winner_q <= 1'b0;
            tie_q    <= 1'b0;
        end else if ((state == IDLE) && start) begin
            win_cnt  <= WIN_LOAD;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            winner_q <= 1'b0;
            tie_q    <= 1'b0;
        end else if (state == ACCUM) begin
            cnt_a_q <= cnt_a_nxt;
            cnt_b_q <= cnt_b_nxt;
            if (!last_sample) begin
                win_cnt <= win_cnt - 1'b1;
            end
            // Verdict uses the post-update counts so the final sampled cycle is included.
            if (state_nxt == HOLD) begin
                winner_q <= (cnt_b_nxt > cnt_a_nxt);
                tie_q    <= (cnt_b_nxt == cnt_a_nxt);
            end
        end
    end

    always_comb begin
        busy         = (state == ACCUM);
        result_valid = (state == HOLD);
        winner       = winner_q;
        tie          = tie_q;
        count_a      = cnt_a_q;
        count_b      = cnt_b_q;
    end

endmodule

// File: tb/tb_snn_spike_decoder.sv
// Directed self-checking bench for snn_spike_decoder: window latency, saturation, tie, handshake, reset.
// A second instance with WINDOW=200 covers counter saturation.
module tb_snn_spike_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       start_sat;
    logic       data_in_a;
    logic       sign_in_a;
    logic       data_in_b;
    logic       sign_in_b;
    logic       result_ready;
    logic       busy;
    logic       result_valid;
    logic       winner;
    logic       tie;
    logic [7:0] count_a;
    logic [7:0] count_b;
    logic       busy_s;
    logic       result_valid_s;
    logic       winner_s;
    logic       tie_s;
    logic [7:0] count_a_s;
    logic [7:0] count_b_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    snn_spike_decoder #(
        .CNT_W (8),
        .WINDOW(64),
        .WIN_W (7),
        .MARGIN(16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .data_in_a   (data_in_a),
        .sign_in_a   (sign_in_a),
        .data_in_b   (data_in_b),
        .sign_in_b   (sign_in_b),
        .result_ready(result_ready),
        .busy        (busy),
        .result_valid(result_valid),
        .winner      (winner),
        .tie         (tie),
        .count_a     (count_a),
        .count_b     (count_b)
    );

    snn_spike_decoder #(
        .CNT_W (8),
        .WINDOW(200),
        .WIN_W (8),
        .MARGIN(16)
    ) dut_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start_sat),
        .data_in_a   (data_in_a),
        .sign_in_a   (sign_in_a),
        .data_in_b   (data_in_b),
        .sign_in_b   (sign_in_b),
        .result_ready(result_ready),
        .busy        (busy_s),
        .result_valid(result_valid_s),
        .winner      (winner_s),
        .tie         (tie_s),
        .count_a     (count_a_s),
        .count_b     (count_b_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a window and drives p positive then n negative spikes per channel, silent afterwards.
    task automatic run_window(input int pa, input int na, input int pb, input int nb,
                              input int nwin, input bit use_sat);
        start     = !use_sat;
        start_sat = use_sat;
        data_in_a = 1'b0;
        data_in_b = 1'b0;
        tick();
        start     = 1'b0;
        start_sat = 1'b0;
        for (int unsigned i = 0; i < nwin; i++) begin
            data_in_a = (i < pa + na);
            sign_in_a = !(i < pa);
            data_in_b = (i < pb + nb);
            sign_in_b = !(i < pb);
            tick();
        end
        data_in_a = 1'b0;
        data_in_b = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start_sat = 1'b0; result_ready = 1'b0;
        data_in_a = 1'b0; sign_in_a = 1'b0; data_in_b = 1'b0; sign_in_b = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({busy, result_valid, winner, tie, count_a, count_b} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b valid=%b win=%b tie=%b a=%0d b=%0d, want all 0",
                     busy, result_valid, winner, tie, count_a, count_b);
        end
        n_checks++;
        if ({busy_s, result_valid_s, winner_s, tie_s, count_a_s, count_b_s} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs_sat: got busy=%b valid=%b a=%0d b=%0d, want all 0",
                     busy_s, result_valid_s, count_a_s, count_b_s);
        end
        rst_n = 1'b1;
        data_in_a = 1'b1; sign_in_a = 1'b0; data_in_b = 1'b1; sign_in_b = 1'b1;
        repeat (10) tick();
        n_checks++;
        if ({busy, result_valid, count_a, count_b} !== 18'h0) begin
            n_fail++;
            $display("FAIL idle_spikes_ignored: got busy=%b valid=%b a=%0d b=%0d, want 0 0 0 0",
                     busy, result_valid, count_a, count_b);
        end
        data_in_a = 1'b0; data_in_b = 1'b0;
    endtask

    task automatic test_window();
        start = 1'b1;
        data_in_a = 1'b1; sign_in_a = 1'b0; data_in_b = 1'b0; sign_in_b = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if ({busy, count_a} !== {1'b1, 8'd0}) begin
            n_fail++;
            $display("FAIL window_enter: got busy=%b a=%0d, want busy=1 a=0", busy, count_a);
        end
        repeat (63) tick();
        n_checks++;
        if ({busy, result_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL window_not_early: got busy=%b valid=%b after 64 edges, want 1 0",
                     busy, result_valid);
        end
        tick();
        n_checks++;
        if ({busy, result_valid, winner, tie, count_a, count_b} !== {4'b0100, 8'd64, 8'd0}) begin
            n_fail++;
            $display("FAIL window_result: got busy=%b valid=%b win=%b tie=%b a=%0d b=%0d, want 0 1 0 0 64 0",
                     busy, result_valid, winner, tie, count_a, count_b);
        end
        data_in_a = 1'b0;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        n_checks++;
        if ({busy, result_valid, count_a} !== {2'b00, 8'd64}) begin
            n_fail++;
            $display("FAIL window_release: got busy=%b valid=%b a=%0d, want 0 0 64",
                     busy, result_valid, count_a);
        end
    endtask

    task automatic test_saturation();
        run_window(200, 0, 0, 200, 200, 1'b1);
        n_checks++;
        if ({result_valid_s, winner_s, tie_s, count_a_s, count_b_s} !== {3'b100, 8'd127, 8'h80}) begin
            n_fail++;
            $display("FAIL saturation: got valid=%b win=%b tie=%b a=%0d b=%0d, want 1 0 0 127 -128",
                     result_valid_s, winner_s, tie_s, $signed(count_a_s), $signed(count_b_s));
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        n_checks++;
        if (result_valid_s !== 1'b0) begin
            n_fail++;
            $display("FAIL saturation_release: got valid=%b, want 0", result_valid_s);
        end
    endtask

    task automatic test_tie();
        run_window(10, 3, 10, 3, 64, 1'b0);
        n_checks++;
        if ({result_valid, winner, tie, count_a, count_b} !== {3'b101, 8'd7, 8'd7}) begin
            n_fail++;
            $display("FAIL tie: got valid=%b win=%b tie=%b a=%0d b=%0d, want 1 0 1 7 7",
                     result_valid, winner, tie, count_a, count_b);
        end
    endtask

    // Continues from the HOLD state left by test_tie and leaves a fresh window running.
    task automatic test_handshake();
        result_ready = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            start = (i == 2);
            data_in_a = 1'b1; sign_in_a = 1'b0;
            tick();
            n_checks++;
            if ({result_valid, busy, tie, winner, count_a, count_b} !== {4'b1010, 8'd7, 8'd7}) begin
                n_fail++;
                $display("FAIL hold_stable[%0d]: got valid=%b busy=%b tie=%b win=%b a=%0d b=%0d, want 1 0 1 0 7 7",
                         i, result_valid, busy, tie, winner, count_a, count_b);
            end
        end
        start = 1'b0; data_in_a = 1'b0;
        result_ready = 1'b1;
        tick();
        n_checks++;
        if ({result_valid, busy, tie, count_a, count_b} !== {3'b001, 8'd7, 8'd7}) begin
            n_fail++;
            $display("FAIL handshake_idle: got valid=%b busy=%b tie=%b a=%0d b=%0d, want 0 0 1 7 7",
                     result_valid, busy, tie, count_a, count_b);
        end
        tick();
        result_ready = 1'b0;
        n_checks++;
        if ({result_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL ready_in_idle: got valid=%b busy=%b, want 0 0", result_valid, busy);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if ({busy, tie, winner, count_a, count_b} !== {3'b100, 8'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL restart_clears: got busy=%b tie=%b win=%b a=%0d b=%0d, want 1 0 0 0 0",
                     busy, tie, winner, count_a, count_b);
        end
    endtask

    task automatic test_reset_mid();
        data_in_a = 1'b1; sign_in_a = 1'b0; data_in_b = 1'b1; sign_in_b = 1'b0;
        repeat (20) tick();
        n_checks++;
        if ({busy, count_a, count_b} !== {1'b1, 8'd20, 8'd20}) begin
            n_fail++;
            $display("FAIL mid_window_counts: got busy=%b a=%0d b=%0d, want 1 20 20",
                     busy, count_a, count_b);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, result_valid, count_a, count_b} !== 18'h0) begin
            n_fail++;
            $display("FAIL async_reset_abort: got busy=%b valid=%b a=%0d b=%0d, want 0 0 0 0",
                     busy, result_valid, count_a, count_b);
        end
        tick();
        rst_n = 1'b1;
        data_in_a = 1'b0; data_in_b = 1'b0;
        tick();
    endtask

    task automatic test_winner();
        run_window(0, 2, 5, 0, 64, 1'b0);
        n_checks++;
        if ({result_valid, winner, tie, count_a, count_b} !== {3'b110, 8'hFE, 8'd5}) begin
            n_fail++;
            $display("FAIL winner_b: got valid=%b win=%b tie=%b a=%0d b=%0d, want 1 1 0 -2 5",
                     result_valid, winner, tie, $signed(count_a), $signed(count_b));
        end
        result_ready = 1'b1; tick(); result_ready = 1'b0;
        run_window(0, 3, 0, 5, 64, 1'b0);
        n_checks++;
        if ({result_valid, winner, tie, count_a, count_b} !== {3'b100, 8'hFD, 8'hFB}) begin
            n_fail++;
            $display("FAIL winner_signed: got valid=%b win=%b tie=%b a=%0d b=%0d, want 1 0 0 -3 -5",
                     result_valid, winner, tie, $signed(count_a), $signed(count_b));
        end
        result_ready = 1'b1; tick(); result_ready = 1'b0;
    endtask

`ifdef SNN_DECODE_EARLY_EXIT_EN
    task automatic test_early_exit();
        start = 1'b1;
        data_in_a = 1'b0; data_in_b = 1'b1; sign_in_b = 1'b0;
        tick();
        start = 1'b0;
        repeat (15) tick();
        n_checks++;
        if ({busy, result_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL early_exit_not_yet: got busy=%b valid=%b, want 1 0", busy, result_valid);
        end
        tick();
        n_checks++;
        if ({result_valid, winner, count_a, count_b} !== {2'b11, 8'd0, 8'd16}) begin
            n_fail++;
            $display("FAIL early_exit: got valid=%b win=%b a=%0d b=%0d, want 1 1 0 16",
                     result_valid, winner, count_a, count_b);
        end
        data_in_b = 1'b0;
        result_ready = 1'b1; tick(); result_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
`ifndef SNN_DECODE_EARLY_EXIT_EN
        test_window();
        test_saturation();
`endif
        test_tie();
        test_handshake();
        test_reset_mid();
        test_winner();
`ifdef SNN_DECODE_EARLY_EXIT_EN
        test_early_exit();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
